sevenseg_decode: RTL and testbench

- Inverse of the display encoder path: takes four active-low 7-segment digit patterns (seg3 = thousands … seg0 = ones) and reconstructs the 14-bit binary value.
- Used to read back and self-check the display outputs, and to accept values from panel-style 7-seg sources.
- Multi-cycle: latch, decode each digit, then accumulate acc = acc*10 + digit, most-significant digit first, one digit per clock. Start/done handshake plus an optional auto-retrigger on pattern change.

---
 rtl/sevenseg_decode.sv | 125 ++++++++++++
 tb/tb_sevenseg_decode.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_decode.sv
// Reconstructs a 14-bit binary value from four active-low 7-segment digit patterns.
// Digits are latched on a trigger and accumulated most-significant first, one per clock.
module sevenseg_decode #(
  parameter bit AUTO_MODE   = 1'b0,
  parameter bit ACCEPT_ALT9 = 1'b1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [6:0]  seg0,
  input  logic [6:0]  seg1,
  input  logic [6:0]  seg2,
  input  logic [6:0]  seg3,
  input  logic        start,
  output logic [13:0] number,
  output logic        done,
  output logic        busy,
  output logic [3:0]  digitErr,
  output logic        error
);

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  state_e          state_q, state_d;
  logic [3:0][6:0] pat_q;
  logic [3:0][6:0] seg_all;
  logic [13:0]     acc_q;
  logic [13:0]     acc_next;
  logic [1:0]      idx_q;
  logic [3:0]      err_acc_q;
  logic [13:0]     number_q;
  logic [3:0]      digit_err_q;
  logic            done_q;
  logic            busy_q;
  logic            error_q;
  logic [6:0]      lit;
  logic [3:0]      dig;
  logic            dig_err;
  logic            trigger;
  logic [3:0]      final_err;

  assign seg_all = {seg3, seg2, seg1, seg0};

  // Segment decode on the lit-high form of the currently selected digit.
  always_comb begin
    lit     = ~pat_q[idx_q];
    dig     = 4'd0;
    dig_err = 1'b0;
    case (lit)
      7'h3F:   dig = 4'd0;
      7'h06:   dig = 4'd1;
      7'h5B:   dig = 4'd2;
      7'h4F:   dig = 4'd3;
      7'h66:   dig = 4'd4;
      7'h6D:   dig = 4'd5;
      7'h7D:   dig = 4'd6;
      7'h07:   dig = 4'd7;
      7'h7F:   dig = 4'd8;
      7'h67:   dig = 4'd9;
      7'h6F: begin
        if (ACCEPT_ALT9) dig = 4'd9;
        else             dig_err = 1'b1;
      end
      default: dig_err = 1'b1;
    endcase
  end

  assign acc_next  = (acc_q << 3) + (acc_q << 1) + {10'd0, dig};
  assign final_err = {err_acc_q[3:1], dig_err};
  assign trigger   = (state_q == StIdle) && (start || (AUTO_MODE && (seg_all != pat_q)));

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (trigger) state_d = StAccum;
      StAccum: if (idx_q == 2'd0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pat_q       <= {4{7'h40}};
      acc_q       <= 14'd0;
      idx_q       <= 2'd3;
      err_acc_q   <= 4'd0;
      number_q    <= 14'd0;
      digit_err_q <= 4'd0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (trigger) begin
        pat_q     <= seg_all;
        acc_q     <= 14'd0;
        idx_q     <= 2'd3;
        err_acc_q <= 4'd0;
        busy_q    <= 1'b1;
      end else if (state_q == StAccum) begin
        acc_q            <= acc_next;
        err_acc_q[idx_q] <= dig_err;
        idx_q            <= idx_q - 2'd1;
        if (idx_q == 2'd0) begin
          number_q    <= acc_next;
          digit_err_q <= final_err;
          error_q     <= |final_err;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
        end
      end
    end
  end

  assign number   = number_q;
  assign digitErr = digit_err_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign error    = error_q;

endmodule

// File: tb/tb_sevenseg_decode.sv
// Self-checking bench for sevenseg_decode: vector table, random patterns against a digit-lookup
// model, and hand-written sequences for back-to-back, auto-trigger and mid-conversion reset.
module tb_sevenseg_decode;

  logic        clock = 1'b0;
  logic        resetn = 1'b1;
  logic [6:0]  seg0, seg1, seg2, seg3;
  logic        start;
  logic [13:0] number, n_number, a_number;
  logic        done, busy, error, n_done, n_busy, n_error, a_done, a_busy, a_error;
  logic [3:0]  digit_err, n_digit_err, a_digit_err;
  logic [6:0]  a_seg0, a_seg1, a_seg2, a_seg3;
  logic        a_start;

  sevenseg_decode #(.AUTO_MODE(1'b0), .ACCEPT_ALT9(1'b1)) u_dut (
    .clock(clock), .resetn(resetn), .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
    .start(start), .number(number), .done(done), .busy(busy), .digitErr(digit_err),
    .error(error)
  );

  sevenseg_decode #(.AUTO_MODE(1'b0), .ACCEPT_ALT9(1'b0)) u_noalt (
    .clock(clock), .resetn(resetn), .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
    .start(start), .number(n_number), .done(n_done), .busy(n_busy), .digitErr(n_digit_err),
    .error(n_error)
  );

  sevenseg_decode #(.AUTO_MODE(1'b1), .ACCEPT_ALT9(1'b1)) u_auto (
    .clock(clock), .resetn(resetn), .seg0(a_seg0), .seg1(a_seg1), .seg2(a_seg2),
    .seg3(a_seg3), .start(a_start), .number(a_number), .done(a_done), .busy(a_busy),
    .digitErr(a_digit_err), .error(a_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic [6:0] s3, s2, s1, s0;
    int         num;
    logic [3:0] err;
    int         num0;
    logic [3:0] err0;
  } vec_t;

  logic [6:0] lit_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h67};

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int a_done_cnt = 0;

  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (done)   done_cnt   <= done_cnt + 1;
    if (a_done) a_done_cnt <= a_done_cnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: look each lit pattern up in the digit table, then weight by powers of ten.
  function automatic void model(input logic [6:0] s3, s2, s1, s0, input bit alt9,
                                output int num, output logic [3:0] err);
    logic [6:0] s [4];
    logic [6:0] p;
    int         d;
    bit         ok;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    num = 0;
    err = 4'd0;
    for (int i = 3; i >= 0; i--) begin
      p  = ~s[i];
      d  = 0;
      ok = 1'b0;
      for (int k = 0; k < 10; k++) if (p == lit_tab[k]) begin d = k; ok = 1'b1; end
      if (alt9 && p == 7'h6F) begin d = 9; ok = 1'b1; end
      err[i] = !ok;
      num    = num * 10 + d;
    end
  endfunction

  task automatic wait_done(output int at, output bit got);
    got = 1'b0;
    at  = -1;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clock);
      if (done) begin got = 1'b1; at = cyc; end
    end
  endtask

  task automatic run_conv(input string name, input logic [6:0] s3, s2, s1, s0,
                          input int en, input logic [3:0] ee, input int en0,
                          input logic [3:0] ee0);
    int t0;
    int busy_n;
    int lat;
    bit got;
    @(negedge clock);
    seg3 = s3; seg2 = s2; seg1 = s1; seg0 = s0;
    start = 1'b1;
    @(posedge clock);
    #1;
    t0     = cyc;
    start  = 1'b0;
    busy_n = 0;
    got    = 1'b0;
    lat    = -1;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clock);
      if (done) begin got = 1'b1; lat = cyc - t0; end
      else if (busy) busy_n++;
    end
    check({name, " done_seen"}, int'(got), 1);
    check({name, " latency"}, lat, 4);
    check({name, " busy_cycles"}, busy_n, 4);
    check({name, " number"}, int'(number), en);
    check({name, " digitErr"}, int'(digit_err), int'(ee));
    check({name, " error"}, int'(error), int'(|ee));
    check({name, " noalt_number"}, int'(n_number), en0);
    check({name, " noalt_digitErr"}, int'(n_digit_err), int'(ee0));
    @(negedge clock);
    check({name, " done_one_cycle"}, int'(done), 0);
  endtask

  function automatic logic [6:0] pick_pat();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)       pick_pat = ~lit_tab[$urandom_range(0, 9)];
    else if (r == 7) pick_pat = ~7'h6F;
    else             pick_pat = 7'($urandom_range(0, 127));
  endfunction

  vec_t vecs [8];

  initial begin
    int         en, en0, at, t0, snap;
    bit         got;
    logic [3:0] ee, ee0;
    logic [6:0] r3, r2, r1, r0;
    int         held_exp [3];

    vecs[0] = '{"v0123", ~7'h3F, ~7'h06, ~7'h5B, ~7'h4F, 123, 4'h0, 123, 4'h0};
    vecs[1] = '{"v9999_67", ~7'h67, ~7'h67, ~7'h67, ~7'h67, 9999, 4'h0, 9999, 4'h0};
    vecs[2] = '{"v9999_6F", ~7'h6F, ~7'h6F, ~7'h6F, ~7'h6F, 9999, 4'h0, 0, 4'hF};
    vecs[3] = '{"v4_56", ~7'h66, ~7'h00, ~7'h6D, ~7'h7D, 4056, 4'b0100, 4056, 4'b0100};
    vecs[4] = '{"v0000", ~7'h3F, ~7'h3F, ~7'h3F, ~7'h3F, 0, 4'h0, 0, 4'h0};
    vecs[5] = '{"v8888", ~7'h7F, ~7'h7F, ~7'h7F, ~7'h7F, 8888, 4'h0, 8888, 4'h0};
    vecs[6] = '{"vblank", ~7'h00, ~7'h00, ~7'h00, ~7'h00, 0, 4'hF, 0, 4'hF};
    vecs[7] = '{"v9791", ~7'h6F, ~7'h07, ~7'h6F, ~7'h06, 9791, 4'h0, 701, 4'b1010};

    seg3 = ~7'h3F; seg2 = ~7'h3F; seg1 = ~7'h3F; seg0 = ~7'h3F;
    a_seg3 = ~7'h3F; a_seg2 = ~7'h3F; a_seg1 = ~7'h3F; a_seg0 = ~7'h3F;
    start = 1'b0;
    a_start = 1'b0;

    #2 resetn = 1'b0;
    repeat (3) @(negedge clock);
    check("reset number", int'(number), 0);
    check("reset done", int'(done), 0);
    check("reset busy", int'(busy), 0);
    check("reset digitErr", int'(digit_err), 0);
    check("reset error", int'(error), 0);
    resetn = 1'b1;

    // Auto-trigger: a "0000" input after reset matches the reset capture.
    repeat (20) @(negedge clock);
    #1;
    check("auto no_done_on_0000", a_done_cnt, 0);
    a_seg0 = ~7'h06;
    repeat (12) @(negedge clock);
    #1;
    check("auto one_conv", a_done_cnt, 1);
    check("auto number", int'(a_number), 1);
    check("auto digitErr", int'(a_digit_err), 0);
    repeat (20) @(negedge clock);
    #1;
    check("auto steady_no_more", a_done_cnt, 1);
    @(negedge clock);
    a_seg1  = ~7'h06;
    a_start = 1'b1;
    @(posedge clock);
    #1 a_start = 1'b0;
    repeat (20) @(negedge clock);
    #1;
    check("auto start_and_mismatch_single", a_done_cnt, 2);
    check("auto number11", int'(a_number), 11);

    foreach (vecs[i])
      run_conv(vecs[i].name, vecs[i].s3, vecs[i].s2, vecs[i].s1, vecs[i].s0,
               vecs[i].num, vecs[i].err, vecs[i].num0, vecs[i].err0);

    for (int i = 0; i < 24; i++) begin
      r3 = pick_pat(); r2 = pick_pat(); r1 = pick_pat(); r0 = pick_pat();
      model(r3, r2, r1, r0, 1'b1, en, ee);
      model(r3, r2, r1, r0, 1'b0, en0, ee0);
      run_conv($sformatf("rand%0d", i), r3, r2, r1, r0, en, ee, en0, ee0);
    end

    // start held high: triggers at T, T+5, T+10; the mid-flight input change lands in the second.
    @(negedge clock);
    seg3 = ~7'h06; seg2 = ~7'h5B; seg1 = ~7'h4F; seg0 = ~7'h66;
    start = 1'b1;
    @(posedge clock);
    #1 t0 = cyc;
    @(posedge clock);
    #1;
    seg3 = ~7'h6D; seg2 = ~7'h7D; seg1 = ~7'h07; seg0 = ~7'h7F;
    held_exp[0] = 1234; held_exp[1] = 5678; held_exp[2] = 5678;
    for (int k = 0; k < 3; k++) begin
      wait_done(at, got);
      if (k == 2) start = 1'b0;
      check($sformatf("held%0d done_seen", k), int'(got), 1);
      check($sformatf("held%0d done_cycle", k), at - t0, 4 + 5 * k);
      check($sformatf("held%0d number", k), int'(number), held_exp[k]);
    end
    repeat (10) @(negedge clock);
    check("held no_extra_busy", int'(busy), 0);

    // Reset two edges into an "8888" conversion aborts it without a done pulse.
    @(negedge clock);
    seg3 = ~7'h7F; seg2 = ~7'h7F; seg1 = ~7'h7F; seg0 = ~7'h7F;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 resetn = 1'b0;
    #1;
    snap = done_cnt;
    check("midreset busy", int'(busy), 0);
    check("midreset number", int'(number), 0);
    check("midreset done", int'(done), 0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (10) @(negedge clock);
    #1;
    check("midreset no_done", done_cnt - snap, 0);
    check("midreset number_held0", int'(number), 0);
    run_conv("after_reset8888", ~7'h7F, ~7'h7F, ~7'h7F, ~7'h7F, 8888, 4'h0, 8888, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
